// File: rtl/mips_mem_pkg.sv
// Shared definitions for the M-stage data-memory responder: FSM state
// encoding, legal store byte-enable patterns and the wait counter width.
package mips_mem_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;

    // True for the byte-enable patterns a word/half/byte store can produce.
    function automatic logic be_is_legal(input logic [3:0] be);
        logic legal;
        case (be)
            BE_WORD, BE_HALF_LO, BE_HALF_HI,
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// M-stage data-memory bus: request fields from the pipeline, completion
// pulse, load word, stall and byte-enable error back from the responder.
interface dmem_if;
    logic        req_M;
    logic        we_M;
    logic [31:0] addr_M;
    logic [3:0]  byte_en_M;
    logic [31:0] mem_in_M;
    logic [31:0] mem_out_M;
    logic        ack_M;
    logic        stall_M;
    logic        err_M;

    modport master (
        output req_M, we_M, addr_M, byte_en_M, mem_in_M,
        input  mem_out_M, ack_M, stall_M, err_M
    );

    modport slave (
        input  req_M, we_M, addr_M, byte_en_M, mem_in_M,
        output mem_out_M, ack_M, stall_M, err_M
    );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word array with per-lane write enables and a
// registered read port. The read register holds its value until the next
// read enable; storage itself is never cleared by reset.
module dmem_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    output logic [31:0]       rd_data
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rd_data_r;

    // Lane-wise write of the storage array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem_r[addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Registered read; the captured word is held between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_r <= 32'h0000_0000;
        end else if (rd_en) begin
            rd_data_r <= mem_r[addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder. Accepts one access at a time, waits
// WAIT_STATES cycles, commits the store or load on the last WAIT edge and
// pulses ack_M in the following cycle. stall_M holds the pipeline until ack.
// Optional feature macro: DMEM_BE_CHECK_EN -- rejects store byte-enable
// patterns that no word/half/byte store can produce, flags err_M with the
// ack and suppresses the write.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic  clk,
    input  logic  reset_n,
    dmem_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

    dmem_state_e           state_r;
    dmem_state_e           state_s;
    logic [WAIT_CNT_W-1:0] cnt_r;
    logic                  ack_r;
    logic                  commit_s;
    logic                  be_fault_s;
    logic [3:0]            wr_be_s;
    logic                  rd_en_s;
    logic [31:0]           rd_data_s;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and commit strobe.
    always_comb begin
        state_s  = state_r;
        commit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_M) begin
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == '0) begin
                    commit_s = 1'b1;
                    state_s  = RESP;
                end else begin
                    state_s  = WAIT;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Wait-state counter: loaded on acceptance, counts down while waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if ((state_r == IDLE) && bus.req_M) begin
            cnt_r <= WAIT_INIT;
        end else if ((state_r == WAIT) && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Completion pulse: high for the single RESP cycle after commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= commit_s;
        end
    end

`ifdef DMEM_BE_CHECK_EN
    logic err_r;

    assign be_fault_s = bus.we_M & ~be_is_legal(bus.byte_en_M);

    // Error pulse aligned with ack for a rejected store pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= commit_s & be_fault_s;
        end
    end

    assign bus.err_M = err_r;
`else
    assign be_fault_s = 1'b0;
    assign bus.err_M  = 1'b0;
`endif

    // Lane enables and read strobe, both gated to the commit edge.
    always_comb begin
        wr_be_s = 4'b0000;
        rd_en_s = 1'b0;
        if (commit_s) begin
            if (bus.we_M) begin
                if (be_fault_s) begin
                    wr_be_s = 4'b0000;
                end else begin
                    wr_be_s = bus.byte_en_M;
                end
            end else begin
                rd_en_s = 1'b1;
            end
        end else begin
            wr_be_s = 4'b0000;
            rd_en_s = 1'b0;
        end
    end

    dmem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (bus.addr_M[ADDR_W+1:2]),
        .wr_be   (wr_be_s),
        .wr_data (bus.mem_in_M),
        .rd_en   (rd_en_s),
        .rd_data (rd_data_s)
    );

    assign bus.mem_out_M = rd_data_s;
    assign bus.ack_M     = ack_r;
    assign bus.stall_M   = bus.req_M & ~ack_r;

endmodule
